// File: rtl/cla_pkg.sv
// ============================================================================
// Module      : cla_pkg
// Description : Shared types and helpers for the pipelined CLA adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int MAX_WIDTH = 256;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int num_blocks(input int width, input int block);
    return width / block;
  endfunction

  // Signed max/min patterns, generated wide and truncated by the caller.
  function automatic logic [MAX_WIDTH-1:0] smax_gen(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] smin_gen(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_block.sv
// ============================================================================
// Module      : cla_block
// Description : Combinational BLOCK-bit lookahead carry block with group G/P.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] p,
  input  logic [BLOCK-1:0] g,
  input  logic             cin,
  output logic [BLOCK-1:0] c,
  output logic             group_g,
  output logic             group_p
);

  logic [BLOCK:0] gen;
  logic [BLOCK:0] prop;
  logic           term;

  // gen[i]/prop[i]: generate/propagate of bits [i-1:0], each a flat sum of products.
  always_comb begin
    gen  = '0;
    prop = '0;
    term = 1'b0;
    c    = '0;
    prop[0] = 1'b1;
    for (int i = 1; i <= BLOCK; i++) begin
      prop[i] = prop[i-1] & p[i-1];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        gen[i] = gen[i] | term;
      end
    end
    for (int i = 0; i < BLOCK; i++) c[i] = gen[i] | (prop[i] & cin);
    group_g = gen[BLOCK];
    group_p = prop[BLOCK];
  end

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module      : cla_pipe_adder
// Description : Two-stage pipelined hierarchical CLA adder/subtractor with
//               valid/ready handshake. CLA_PIPE_SATURATE_EN adds a 'sat' port
//               enabling signed saturation on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_PIPE_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = num_blocks(WIDTH, BLOCK);

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK");
  end
  if (!(BLOCK == 2 || BLOCK == 4 || BLOCK == 8)) begin : g_bad_block
    $error("cla_pipe_adder: BLOCK must be 2, 4 or 8");
  end

`ifdef CLA_PIPE_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax_gen(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin_gen(WIDTH));
`endif

  logic en1;
  logic en2;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] g_q, g_d;
  gp_t  [NB-1:0]    gp_q, gp_d;
  logic             c0_q, c0_d;
`ifdef CLA_PIPE_SATURATE_EN
  logic             a_msb_q, a_msb_d;
  logic             sat_q, sat_d;
`endif

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  assign en2      = !out_valid_q || out_ready;
  assign en1      = !s1_valid_q || en2;
  assign in_ready = en1;

  // ---------------------------------------------------------------- stage 1
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] s1_carries;
  logic [NB-1:0]    blk_g_in;
  logic [NB-1:0]    blk_p_in;

  always_comb begin
    b_eff = sub ? ~b : b;
    p_in  = a ^ b_eff;
    g_in  = a & b_eff;
  end

  for (genvar k = 0; k < NB; k++) begin : g_s1_blk
    cla_block #(.BLOCK(BLOCK)) u_blk (
      .p       (p_in[k*BLOCK +: BLOCK]),
      .g       (g_in[k*BLOCK +: BLOCK]),
      .cin     (1'b0),
      .c       (s1_carries[k*BLOCK +: BLOCK]),
      .group_g (blk_g_in[k]),
      .group_p (blk_p_in[k])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    g_d        = g_q;
    gp_d       = gp_q;
    c0_d       = c0_q;
`ifdef CLA_PIPE_SATURATE_EN
    a_msb_d    = a_msb_q;
    sat_d      = sat_q;
`endif
    if (en1) begin
      s1_valid_d = in_valid;
      p_d        = p_in;
      g_d        = g_in;
      c0_d       = sub | cin;
      for (int k = 0; k < NB; k++) begin
        gp_d[k].g = blk_g_in[k];
        gp_d[k].p = blk_p_in[k];
      end
`ifdef CLA_PIPE_SATURATE_EN
      a_msb_d    = a[WIDTH-1];
      sat_d      = sat;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      c0_q       <= 1'b0;
`ifdef CLA_PIPE_SATURATE_EN
      a_msb_q    <= 1'b0;
      sat_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      p_q        <= p_d;
      g_q        <= g_d;
      gp_q       <= gp_d;
      c0_q       <= c0_d;
`ifdef CLA_PIPE_SATURATE_EN
      a_msb_q    <= a_msb_d;
      sat_q      <= sat_d;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [NB:0]      blk_c;
  logic             term;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] raw_sum;
  logic             raw_cout;
  logic             raw_ovf;
  logic [NB-1:0]    s2_grp_g;
  logic [NB-1:0]    s2_grp_p;

  // Block carries as flat sum of products over registered block G/P.
  always_comb begin
    blk_c    = '0;
    term     = 1'b0;
    blk_c[0] = c0_q;
    for (int k = 1; k <= NB; k++) begin
      term = c0_q;
      for (int m = 0; m < k; m++) term = term & gp_q[m].p;
      blk_c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gp_q[j].g;
        for (int m = j + 1; m < k; m++) term = term & gp_q[m].p;
        blk_c[k] = blk_c[k] | term;
      end
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_s2_blk
    cla_block #(.BLOCK(BLOCK)) u_blk (
      .p       (p_q[k*BLOCK +: BLOCK]),
      .g       (g_q[k*BLOCK +: BLOCK]),
      .cin     (blk_c[k]),
      .c       (bit_c[k*BLOCK +: BLOCK]),
      .group_g (s2_grp_g[k]),
      .group_p (s2_grp_p[k])
    );
  end

  always_comb begin
    raw_sum  = p_q ^ bit_c;
    raw_cout = blk_c[NB];
    raw_ovf  = bit_c[WIDTH-1] ^ raw_cout;
`ifdef CLA_PIPE_SATURATE_EN
    if (sat_q && raw_ovf) raw_sum = a_msb_q ? SMIN : SMAX;
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (en2) begin
      out_valid_d = s1_valid_q;
      sum_d       = raw_sum;
      cout_d      = raw_cout;
      ovf_d       = raw_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Stage-1 intra-block carries and stage-2 group terms are structurally unused.
  logic unused_cla_terms;
  assign unused_cla_terms = ^{s1_carries, s2_grp_g, s2_grp_p};

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Scoreboard bench for cla_pipe_adder (directed, stall, reset,
//               random backpressure).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;

  localparam int W = 16;
  localparam int B = 4;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, sat, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef CLA_PIPE_SATURATE_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [31:0]  cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           pops = 0;
  bit           chk_lat = 1'b0;
  bit           last_acc = 1'b0;
  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub, input logic msat);
    exp_t         m;
    logic [W-1:0] be;
    logic [W:0]   full;
    be     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    m.sum  = full[W-1:0];
    m.cout = full[W];
    m.ovf  = (ma[W-1] == be[W-1]) && (m.sum[W-1] != ma[W-1]);
`ifdef CLA_PIPE_SATURATE_EN
    if (msat && m.ovf) m.sum = ma[W-1] ? SMIN : SMAX;
`else
    if (msat) m.sum = m.sum;
`endif
    m.cyc  = 32'(cyc);
    return m;
  endfunction

  // One clock: sample mid-cycle, score transfers, advance past the edge.
  task automatic step();
    exp_t e;
    #4;
    last_acc = 1'b0;
    if (!rst) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, !(sb.size() == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          last_sum  = sum;
          last_cout = cout;
          last_ovf  = ovf;
          check("sum", {{(64-W){1'b0}}, sum}, {{(64-W){1'b0}}, e.sum});
          check("cout", {63'd0, cout}, {63'd0, e.cout});
          check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          if (chk_lat) check("latency", 64'(cyc - int'(e.cyc)), 64'd2);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub, sat));
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sbv,
                      input logic scin, input logic ssub, input logic ssat);
    bit done;
    done     = 1'b0;
    a        = sa;
    b        = sbv;
    cin      = scin;
    sub      = ssub;
    sat      = ssat;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      step();
      done = last_acc;
    end
    check("send_accept", {63'd0, last_acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    out_ready = 1'b1;
    for (int t = 0; t < maxc && sb.size() > 0; t++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                          input logic dcin, input logic dsub, input logic dsat,
                          input logic [W-1:0] esum, input logic ecout, input logic eovf);
    send(da, db, dcin, dsub, dsat);
    drain(10);
    check({tag, "_sum"}, {{(64-W){1'b0}}, last_sum}, {{(64-W){1'b0}}, esum});
    check({tag, "_cout"}, {63'd0, last_cout}, {63'd0, ecout});
    check({tag, "_ovf"}, {63'd0, last_ovf}, {63'd0, eovf});
  endtask

  initial begin
    logic [W-1:0] held;
    int           p0;
    int           accepted;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {{(64-W){1'b0}}, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors, unstalled, with latency checking.
    chk_lat = 1'b1;
    directed("add_wrap", ONES, 1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    directed("sub_borrow", 5, 7, 1'b0, 1'b1, 1'b0, ONES - 1, 1'b0, 1'b0);
    directed("sub_ovf", SMIN, 1, 1'b0, 1'b1, 1'b0, SMAX, 1'b1, 1'b1);
    directed("add_ovf", SMAX, 1, 1'b0, 1'b0, 1'b0, SMIN, 1'b0, 1'b1);
    directed("add_cin", 3, 4, 1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    directed("sub_cin_ignored", 9, 4, 1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0);
`ifdef CLA_PIPE_SATURATE_EN
    directed("sat_pos", SMAX, 1, 1'b0, 1'b0, 1'b1, SMAX, 1'b0, 1'b1);
    directed("sat_neg", SMIN, 1, 1'b0, 1'b1, 1'b1, SMIN, 1'b1, 1'b1);
`endif
    chk_lat = 1'b0;

    // Stall with two items in flight.
    out_ready = 1'b0;
    send(16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0);
    send(16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b0);
    held = sum;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_sum", {{(64-W){1'b0}}, sum}, {{(64-W){1'b0}}, held});
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    p0 = pops;
    step();
    step();
    check("drain_two", 64'(pops - p0), 64'd2);

    // Reset with a full pipe; the input offered during reset must vanish.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 16'h5555;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", {{(64-W){1'b0}}, sum}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (5) step();

    // Back-to-back random traffic with 50% backpressure.
    accepted = 0;
    p0 = pops;
    in_valid = 1'b1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    for (int t = 0; t < 3000 && accepted < 100; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_acc) begin
        accepted++;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        sat = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check("random_accepted", 64'(accepted), 64'd100);
    drain(20);
    check("random_count", 64'(pops - p0), 64'd100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
